// File: rtl/sram_arbiter.sv
// sram_arbiter: two-requester byte-burst read scheduler for a shared single-port SRAM.
// Ports:
//   clk, n_rst                         clock and synchronous active-low reset
//   coef_req/addr/len                  coefficient burst request, start address, byte count
//   coef_grant/byte/byte_valid/done    coefficient ownership, returned byte and its strobe, end-of-burst pulse
//   img_*                              image-side ports with the same widths and meaning
//   sram_addr, sram_read               SRAM read address and one-cycle read strobe
//   sram_rdata, sram_rvalid            SRAM read data and its valid strobe
//   busy                               high whenever the scheduler is not idle
// Build option: define SRAM_ARB_COEF_PRIO_EN for fixed coefficient priority;
// otherwise ties are broken round-robin.
module sram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              coef_req,
    input  logic [ADDR_W-1:0] coef_addr,
    input  logic [LEN_W-1:0]  coef_len,
    output logic              coef_grant,
    output logic [7:0]        coef_byte,
    output logic              coef_byte_valid,
    output logic              coef_done,
    input  logic              img_req,
    input  logic [ADDR_W-1:0] img_addr,
    input  logic [LEN_W-1:0]  img_len,
    output logic              img_grant,
    output logic [7:0]        img_byte,
    output logic              img_byte_valid,
    output logic              img_done,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_read,
    input  logic [7:0]        sram_rdata,
    input  logic              sram_rvalid,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state;
    logic              owner_img;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remaining;
    logic              pick_img;
    logic [ADDR_W-1:0] sel_addr;
    logic [LEN_W-1:0]  sel_len;

`ifdef SRAM_ARB_COEF_PRIO_EN
    assign pick_img = img_req && !coef_req;
`else
    logic last_img;
    // On a tie the requester that was not served last wins.
    assign pick_img = img_req && (!coef_req || !last_img);
`endif

    assign sel_addr = pick_img ? img_addr : coef_addr;
    assign sel_len  = pick_img ? img_len : coef_len;
    assign busy     = state != IDLE;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state           <= IDLE;
            owner_img       <= 1'b0;
            cur_addr        <= '0;
            remaining       <= '0;
            coef_grant      <= 1'b0;
            coef_byte       <= '0;
            coef_byte_valid <= 1'b0;
            coef_done       <= 1'b0;
            img_grant       <= 1'b0;
            img_byte        <= '0;
            img_byte_valid  <= 1'b0;
            img_done        <= 1'b0;
            sram_addr       <= '0;
            sram_read       <= 1'b0;
`ifndef SRAM_ARB_COEF_PRIO_EN
            last_img        <= 1'b1;
`endif
        end else begin
            coef_byte_valid <= 1'b0;
            img_byte_valid  <= 1'b0;
            coef_done       <= 1'b0;
            img_done        <= 1'b0;
            sram_read       <= 1'b0;
            case (state)
                IDLE: if (coef_req || img_req) begin
                    owner_img  <= pick_img;
                    coef_grant <= !pick_img;
                    img_grant  <= pick_img;
                    cur_addr   <= sel_addr;
                    remaining  <= sel_len;
                    if (sel_len != '0) begin
                        state     <= ISSUE;
                        sram_read <= 1'b1;
                        sram_addr <= sel_addr;
                    end else begin
                        state <= DONE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: if (sram_rvalid) begin
                    if (owner_img) img_byte <= sram_rdata;
                    else coef_byte <= sram_rdata;
                    img_byte_valid  <= owner_img;
                    coef_byte_valid <= !owner_img;
                    cur_addr        <= cur_addr + ADDR_W'(1);
                    remaining       <= remaining - LEN_W'(1);
                    if (remaining == LEN_W'(1)) begin
                        state     <= DONE;
                        img_done  <= owner_img;
                        coef_done <= !owner_img;
                    end else begin
                        state     <= ISSUE;
                        sram_read <= 1'b1;
                        sram_addr <= cur_addr + ADDR_W'(1);
                    end
                end
                DONE: if (!coef_done && !img_done) begin
                    // Zero-length bursts arrive here without a done pulse;
                    // raise it now and leave on the next edge.
                    img_done  <= owner_img;
                    coef_done <= !owner_img;
                end else begin
                    state      <= IDLE;
                    coef_grant <= 1'b0;
                    img_grant  <= 1'b0;
`ifndef SRAM_ARB_COEF_PRIO_EN
                    last_img   <= owner_img;
`endif
                end
            endcase
        end
    end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-requester read scheduler for the shared single-port weight/image SRAM in the neural-net core. The coefficient loader and the image loader each request a burst of byte reads, given as a start address and a length. The arbiter grants one requester at a time and issues one SRAM read per byte, with at most one read outstanding. It returns each byte to the owning requester and pulses a per-requester done at burst end.

## Interface
- ADDR_W, 16, SRAM byte-address width
- LEN_W, 8, burst-length width (0 to 2^LEN_W-1 bytes)

- clk  in  1  system clock; all logic on rising edge
- n_rst  in  1  reset, synchronous, active-low; sampled on rising clk
- coef_req  in  1  coefficient burst request (level)
- coef_addr  in  ADDR_W  coefficient burst start address; sampled at grant
- coef_len  in  LEN_W  coefficient burst byte count; sampled at grant
- coef_grant  out  1  coefficient requester owns SRAM
- coef_byte  out  8  returned byte
- coef_byte_valid  out  1  coef_byte valid this cycle (1-cycle pulse)
- coef_done  out  1  coefficient burst complete (1-cycle pulse)
- img_req, img_addr, img_len, img_grant, img_byte, img_byte_valid, img_done: image-side ports, identical widths and meaning
- sram_addr  out  ADDR_W  SRAM read address
- sram_read  out  1  read strobe (1-cycle pulse per byte)
- sram_rdata  in  8  SRAM read data
- sram_rvalid  in  1  sram_rdata valid; arrives ≥1 cycle after sram_read
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req is high, pick an owner by the arbitration rule.
  - Latch the owner's addr into cur_addr and len into remaining; set the owner's grant.
  - Next state: ISSUE if len≠0, else DONE (zero-length burst makes no SRAM access).
- ISSUE: drive sram_read=1 with sram_addr=cur_addr; next state WAIT.
- WAIT:
  - sram_read=0; sram_addr holds.
  - On sram_rvalid, register sram_rdata to the owner's byte and pulse its byte_valid next cycle; cur_addr+1 (wraps modulo 2^ADDR_W); remaining−1.
  - Next state: DONE if remaining was 1, else ISSUE.
- DONE: pulse the owner's done; record the owner as last_served; next state IDLE; grant deasserts on that transition.
- Arbitration is round-robin. When both req are high in IDLE, the requester other than last_served wins. A single requester always wins. last_served resets to image, so coefficient wins the first tie.
- Requests are levels, and req is ignored while the requester is not in IDLE. A requester must drop req in the cycle it sees done. If req is still high when IDLE is reached, it counts as a new burst.
- sram_rvalid is ignored outside WAIT.
- The non-owner's grant, byte_valid and done stay 0. Its byte output holds its last value.
- Reset values: state IDLE; every grant, byte_valid, done, sram_read and busy = 0; every byte output and sram_addr = 0; remaining and cur_addr = 0; last_served = image.
- Reset mid-burst: next edge forces reset values. The burst is abandoned with no done pulse, and a late sram_rvalid is ignored.

## Timing
- Edge 0: IDLE samples req → grant=1, busy=1 after edge 0.
- sram_read is high in the cycle after edge 0.
- With sram_rvalid one cycle after sram_read:
  - Each byte takes 2 cycles; byte k (1-based) has byte_valid in the cycle after edge 2k.
  - Done is high in the cycle after edge 2N, the same cycle as the last byte_valid; grant drops after edge 2N+1.
- Each extra cycle of SRAM latency adds 1 cycle per byte.
- Zero-length burst: grant after edge 0, done after edge 1, IDLE after edge 2.
- Back-to-back bursts: there is one IDLE cycle between bursts, with no grant overlap.

## Configuration
- SRAM_ARB_COEF_PRIO_EN defined: fixed priority.
  - coef_req always wins over img_req in IDLE.
  - last_served is not used; image can be starved.
- SRAM_ARB_COEF_PRIO_EN undefined: round-robin, as described in Operation.

## Test plan
- Coef only, addr=0x0010, len=3, rvalid 1 cycle after read:
  - sram_addr 0x10, 0x11, 0x12.
  - 3 coef_byte_valid pulses carry the data in order.
  - coef_done is high in the cycle after edge 6; img_* outputs stay 0.
- Both req high from reset, len=1 each:
  - coef served first, then img.
  - With SRAM_ARB_COEF_PRIO_EN and coef_req held high, coef is served twice before img.
- img_addr=0xFFFF, len=2: reads go to 0xFFFF then 0x0000.
- coef_len=0: coef_done after edge 1, with sram_read never asserted.
- SRAM latency 3 cycles, len=2: done in the cycle after edge 8.
  - A spurious sram_rvalid injected during IDLE produces no byte_valid.
- n_rst low for 1 cycle during WAIT of a 4-byte burst:
  - All outputs return to 0 with no done pulse.
  - A subsequent rvalid is ignored.
  - A new request then completes normally.
